rom_string_reader: RTL

- Sequencer that walks a synchronous-read character ROM (8-bit words, registered data one cycle after enable) from a start address.
- Streams each byte to a downstream consumer, e.g. a UART TX or console driver, over a valid/ready handshake.
- Stops on a terminator byte or after a maximum length.
- Sits between the ROM and the character sink; it is the only master of the ROM address/enable pins.

---
 rtl/rom_reader_defs.sv | 21 ++
 rtl/rom_string_reader.sv | 112 +++++++++++
 2 files changed

// File: rtl/rom_reader_defs.sv
// rtl/rom_reader_defs.sv - shared state encoding, terminator default and count width for rom_string_reader
package rom_reader_defs;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_SEND = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    READ = ST_READ,
    WAIT = ST_WAIT,
    SEND = ST_SEND,
    DONE = ST_DONE
  } state_t;

  localparam logic [7:0] DEF_TERM = 8'h00;
  localparam int CNT_W = 7;

endpackage

// File: rtl/rom_string_reader.sv
// rtl/rom_string_reader.sv - walks a sync-read char ROM and streams bytes until TERM or MAX_LEN
// Optional ROM_READER_REPEAT_EN: replay the captured string forever until rst.
module rom_string_reader
  import rom_reader_defs::*;
#(
  parameter int         AW      = 6,
  parameter int         MAX_LEN = 64,
  parameter logic [7:0] TERM    = DEF_TERM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  output logic [AW-1:0]    rom_addr,
  output logic             rom_en,
  input  logic [7:0]       rom_data,
  output logic [7:0]       char_data,
  output logic             char_valid,
  input  logic             char_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] char_count
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LEN);

  state_t state;
  logic   last_char;

`ifdef ROM_READER_REPEAT_EN
  logic [AW-1:0] base_q;
`endif

  assign last_char = (char_count + 1'b1) == MAX_CNT;

  // rom_addr doubles as the walking address register; rom_en is a registered strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      rom_en     <= 1'b0;
      char_data  <= 8'h00;
      char_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
`ifdef ROM_READER_REPEAT_EN
      base_q     <= '0;
`endif
    end else begin
      rom_en <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
`ifdef ROM_READER_REPEAT_EN
            base_q     <= base_addr;
`endif
            rom_addr   <= base_addr;
            char_count <= '0;
            rom_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= READ;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (rom_data == TERM) begin
            done  <= 1'b1;
            state <= DONE;
`ifdef ROM_READER_REPEAT_EN
            char_count <= '0;
`endif
          end else begin
            char_data  <= rom_data;
            char_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (char_ready) begin
            char_valid <= 1'b0;
            char_count <= char_count + 1'b1;
            if (last_char) begin
              done  <= 1'b1;
              state <= DONE;
`ifdef ROM_READER_REPEAT_EN
              char_count <= '0;
`endif
            end else begin
              rom_addr <= rom_addr + 1'b1;
              rom_en   <= 1'b1;
              state    <= READ;
            end
          end
        end
        DONE: begin
`ifdef ROM_READER_REPEAT_EN
          rom_addr <= base_q;
          rom_en   <= 1'b1;
          state    <= READ;
`else
          busy  <= 1'b0;
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
